// File: rtl/gauss_filter_3x3.sv
// gauss_filter_3x3
//   3x3 Gaussian smoothing ([1 2 1; 2 4 2; 1 2 1] / 16, rounded) on a luma
//   stream. Output framing is the input framing delayed by exactly 3 clk.
//   The output for accepted pixel (r,c) is the filter centred at (r-1,c-1).
//   Taps outside the image (row < 0 or col < 0) are zero.
//
//   Optional build macro: GAUSS_BORDER_PASS_EN
//     When defined, any output whose window touches padding (r<2 or c<2)
//     carries the unfiltered centre tap instead of the filtered value.
//
// Ports
//   clk, rst_n                     pixel clock, async active-low reset
//   per_frame_vsync/href/clken     input framing
//   per_img_y   [DATA_WIDTH-1:0]   input luma, valid with clken
//   post_frame_vsync/href/clken    framing delayed by 3 clk
//   post_img_y  [DATA_WIDTH-1:0]   filtered luma, valid with post clken
module gauss_filter_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 1920,
    parameter int ROW_MAX    = 1080
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_y,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic                  post_frame_clken,
    output logic [DATA_WIDTH-1:0] post_img_y
);
    localparam int COL_W = $clog2(DATA_DEPTH);
    localparam int ROW_W = $clog2(ROW_MAX);
    localparam int RS_W  = DATA_WIDTH + 2;
    localparam int SUM_W = DATA_WIDTH + 4;

    // Framing delay lines; bit 0 doubles as the previous-cycle sample for
    // edge detection.
    logic [2:0] vsync_pipe_q, vsync_pipe_d;
    logic [2:0] href_pipe_q,  href_pipe_d;
    logic [2:0] clken_pipe_q, clken_pipe_d;

    logic vsync_rise, href_rise, href_fall;

    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic [COL_W-1:0] col_q, col_d, col_cur;

    // RAM-style line storage, no reset: stale contents are hidden by the
    // row mask applied when a column enters the window.
    logic [DATA_WIDTH-1:0] linebuf0 [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] linebuf1 [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

    // win[row][col]: row 0 = r-2 (top), row 2 = r (bottom); col 2 = newest.
    logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d, win_base;
    logic [2:0][RS_W-1:0]            rs_q, rs_d;
    logic [SUM_W-1:0]                sum_d;
    logic [DATA_WIDTH-1:0]           y_q, y_d;

`ifdef GAUSS_BORDER_PASS_EN
    logic                  border_q, border_d, border2_q, border2_d;
    logic [DATA_WIDTH-1:0] ctr_q, ctr_d;
`endif

    assign vsync_rise = per_frame_vsync & ~vsync_pipe_q[0];
    assign href_rise  = per_frame_href  & ~href_pipe_q[0];
    assign href_fall  = ~per_frame_href & href_pipe_q[0];

    // A pixel arriving together with a vsync/href rising edge already
    // belongs to row 0 / column 0.
    assign row_cur = vsync_rise ? '0 : row_q;
    assign col_cur = href_rise  ? '0 : col_q;

    assign lb0_rd = linebuf0[col_cur];
    assign lb1_rd = linebuf1[col_cur];

    always_comb begin
        vsync_pipe_d = {vsync_pipe_q[1:0], per_frame_vsync};
        href_pipe_d  = {href_pipe_q[1:0],  per_frame_href};
        clken_pipe_d = {clken_pipe_q[1:0], per_frame_clken};

        row_d = row_cur;
        if (!vsync_rise && href_fall && row_q != ROW_W'(ROW_MAX - 1))
            row_d = row_q + 1'b1;

        col_d = col_cur;
        if (per_frame_clken && col_cur != COL_W'(DATA_DEPTH - 1))
            col_d = col_cur + 1'b1;
    end

    // Stage 1: window update. Columns clear on href rising so nothing leaks
    // across lines; rows above the image are masked on entry.
    always_comb begin
        win_base = href_rise ? '0 : win_q;
        win_d    = win_base;
        if (per_frame_clken) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_base[i][1];
                win_d[i][1] = win_base[i][2];
            end
            win_d[0][2] = (row_cur >= ROW_W'(2)) ? lb1_rd : '0;
            win_d[1][2] = (row_cur >= ROW_W'(1)) ? lb0_rd : '0;
            win_d[2][2] = per_img_y;
        end
    end

    // Stage 2: per-row [1 2 1] partial sums.
    always_comb begin
        for (int i = 0; i < 3; i++)
            rs_d[i] = RS_W'(win_q[i][0]) + (RS_W'(win_q[i][1]) << 1) + RS_W'(win_q[i][2]);
    end

    // Stage 3: vertical [1 2 1], round, divide by 16. Peak sum is 255*16,
    // so the +8 never overflows SUM_W and no clamp is required.
    always_comb begin
        sum_d = SUM_W'(rs_q[0]) + (SUM_W'(rs_q[1]) << 1) + SUM_W'(rs_q[2]);
        y_d   = DATA_WIDTH'((sum_d + SUM_W'(8)) >> 4);
`ifdef GAUSS_BORDER_PASS_EN
        border_d  = per_frame_clken ? ((row_cur < ROW_W'(2)) || (col_cur < COL_W'(2)))
                                    : border_q;
        border2_d = border_q;
        ctr_d     = win_q[1][1];
        if (border2_q)
            y_d = ctr_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_pipe_q <= '0;
            href_pipe_q  <= '0;
            clken_pipe_q <= '0;
            row_q        <= '0;
            col_q        <= '0;
            win_q        <= '0;
            rs_q         <= '0;
            y_q          <= '0;
`ifdef GAUSS_BORDER_PASS_EN
            border_q     <= 1'b0;
            border2_q    <= 1'b0;
            ctr_q        <= '0;
`endif
        end else begin
            vsync_pipe_q <= vsync_pipe_d;
            href_pipe_q  <= href_pipe_d;
            clken_pipe_q <= clken_pipe_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_q        <= win_d;
            rs_q         <= rs_d;
            y_q          <= y_d;
`ifdef GAUSS_BORDER_PASS_EN
            border_q     <= border_d;
            border2_q    <= border2_d;
            ctr_q        <= ctr_d;
`endif
        end
    end

    // Line buffers: row r-1 moves down to row r-2 as row r is written.
    always_ff @(posedge clk) begin
        if (per_frame_clken) begin
            linebuf0[col_cur] <= per_img_y;
            linebuf1[col_cur] <= lb0_rd;
        end
    end

    assign post_frame_vsync = vsync_pipe_q[2];
    assign post_frame_href  = href_pipe_q[2];
    assign post_frame_clken = clken_pipe_q[2];
    assign post_img_y       = y_q;

endmodule

// File: doc/gauss_filter_3x3.md
Name: gauss_filter_3x3

Overview:
- 3x3 Gaussian smoothing stage placed directly upstream of the Canny edge detector.
- Takes the luma stream (vsync/href/clken/Y) and produces a denoised luma stream with identical framing.
- The Canny block consumes this output unchanged on its per_frame_*/per_img_y inputs.
- Uses two line buffers, a 3x3 window register array and a 3-stage arithmetic pipeline.

Parameters:
- DATA_WIDTH, 8: pixel bit width of input and output luma.
- DATA_DEPTH, 1920: maximum active pixels per line; sets line-buffer depth. Column counter width is clog2(DATA_DEPTH).
- ROW_MAX, 1080: row counter saturation limit.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous reset, active low; flops clear immediately on assertion, release synchronous to clk.
- per_frame_vsync  in  1  frame sync; rising edge marks a new frame.
- per_frame_href  in  1  line valid; rising edge marks a new line.
- per_frame_clken  in  1  pixel valid; asserted only while href=1.
- per_img_y  in  DATA_WIDTH  input luma, valid when clken=1.
- post_frame_vsync  out  1  vsync delayed by exactly 3 clk.
- post_frame_href  out  1  href delayed by exactly 3 clk.
- post_frame_clken  out  1  clken delayed by exactly 3 clk.
- post_img_y  out  DATA_WIDTH  filtered luma, valid when post_frame_clken=1.

Behaviour:
- Reset:
  - All outputs are 0.
  - Window registers, row/column counters and the sync delay lines clear.
  - Line-buffer contents are don't-care; the row mask below hides them.
- Counters:
  - col clears on href rising and increments per accepted pixel (clken=1).
  - row clears on vsync rising and increments on each href falling edge; saturates at ROW_MAX-1.
  - col saturates at DATA_DEPTH-1. Pixels beyond DATA_DEPTH are filtered with stale buffer data; the block never hangs.
- Window:
  - Each accepted pixel (r,c) shifts the window left one column.
  - New right column = {linebuf1[c] (row r-2), linebuf0[c] (row r-1), per_img_y (row r)}.
  - linebuf0[c] is then written with per_img_y; linebuf1[c] is written with the old linebuf0[c].
  - The output for accepted pixel (r,c) is the filter centred at (r-1,c-1).
- Padding:
  - Window taps at row<0 or col<0 (r<2 or c<2) are forced to 0.
  - Window columns clear on href rising, so no data leaks across lines.
- Arithmetic:
  - Kernel [1 2 1; 2 4 2; 1 2 1].
  - sum = Σ w·p, held at DATA_WIDTH+4 bits (12 bits at default).
  - out = (sum+8)>>4; maximum result is 255, so no saturation is needed.
- Latency:
  - Fixed 3 clk from input clken to post_frame_clken.
  - Pipeline stages: (1) window update, (2) row partial sums, (3) final add and round.
  - vsync/href/clken go through the same 3-deep shift register.
  - The pipeline advances every clk regardless of clken.
- No backpressure: one pixel accepted per clk maximum.
- Output count per line equals input count per line; no extra flush pixels.
- Simultaneous vsync rising and href rising: row clears first, so the line starts as row 0.
- Reset mid-frame:
  - Outputs drop to 0 immediately.
  - The stream resumes at the next vsync rising; a partial frame after release is treated as row 0.

Optional Feature:
- Macro: GAUSS_BORDER_PASS_EN.
- Defined: for any output whose window touches padding (r<2 or c<2), post_img_y equals the unfiltered centre tap p(r-1,c-1), with the same 3-clk latency. A padded centre (r=0 or c=0) outputs 0.
- Undefined: zero-padded filtered result everywhere, as above.

Test Plan:
- Flat frame, all pixels 100, 8x8 (feature off) -> row0 outputs at c≥2 = 25; row1 at c≥2 = 75; rows≥2, c≥2 = 100; rows≥2, c=0 = 25.
- Impulse: 255 at input (5,5), rest 0 -> output at input position (6,6) = 64; (5,6),(7,6),(6,5),(6,7) = 32; (5,5),(5,7),(7,5),(7,7) = 16; all others 0.
- All-255 frame -> interior outputs 255, no wrap; checker confirms internal sum peaks at 4080.
- Timing: href rises at cycle T with clken bursts interleaved with idle cycles -> post_frame_href rises at T+3; every post clken sits exactly 3 clk after its input clken; vsync is delayed identically.
- rst_n asserted mid-line at pixel (3,4) -> all outputs 0 in the same cycle; after release and next vsync, the flat-100 frame result matches the first scenario exactly.
- GAUSS_BORDER_PASS_EN defined, flat 100 frame -> rows 1 and col 1 outputs = 100; row0/col0 = 0; interior = 100.
